trn_tx_arb: RTL and testbench

- Arbitrates the single PCIe TRN transmit interface between NREQ requesters: mem_rd, irq gen, and a future write engine.
- Round-robin grant over the existing req_ep / my_trn / drv_ep handshake.
- Muxes the owner's TRN tx signals onto the endpoint.
- Owns the shared 5-bit non-posted tag counter (tag_trn / tag_inc).

---
 rtl/trn_tx_arb_pkg.sv | 25 ++
 rtl/trn_tx_arb_rr_pick.sv | 41 ++++
 rtl/trn_tx_arb.sv | 176 +++++++++++++++++
 tb/tb_trn_tx_arb.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trn_tx_arb_pkg.sv
`default_nettype none
// =============================================================================
// Module      : trn_tx_arb_pkg
// Description : Shared types and constants for the TRN transmit arbiter.
// Revision    : 1.0 - initial release
// =============================================================================
package trn_tx_arb_pkg;

    // Arbiter FSM encoding
    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GRANT   = 2'd1,
        ARB_BUSY    = 2'd2,
        ARB_RELEASE = 2'd3
    } arb_state_t;

    // Values presented to the endpoint when nobody drives the TRN bus
    localparam logic [7:0]  TREM_IDLE = 8'hFF;
    localparam logic [63:0] TD_IDLE   = 64'h0;

    // Default width of the shared non-posted tag counter
    localparam int TAGW_DEF = 5;

endpackage
`default_nettype wire

// File: rtl/trn_tx_arb_rr_pick.sv
`default_nettype none
// =============================================================================
// Module      : trn_tx_arb_rr_pick
// Description : Combinational round-robin search: returns the first set request
//               at or after the pointer, wrapping from NREQ-1 to 0.
// Revision    : 1.0 - initial release
// =============================================================================
module trn_tx_arb_rr_pick
    import trn_tx_arb_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_ptr,
    output logic [IW-1:0]   o_sel,
    output logic            o_any
);

    // Pick the requester with the smallest wrapped distance from the pointer
    always_comb begin
        int w_dist;
        int w_best;
        w_dist = 0;
        w_best = NREQ;
        o_sel  = '0;
        o_any  = |i_req;
        for (int i = 0; i < NREQ; i++) begin
            w_dist = i - int'(i_ptr);
            if (w_dist < 0) begin
                w_dist = w_dist + NREQ;
            end
            if (i_req[i] && (w_dist < w_best)) begin
                w_best = w_dist;
                o_sel  = IW'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/trn_tx_arb.sv
`default_nettype none
// =============================================================================
// Module      : trn_tx_arb
// Description : Round-robin arbiter for the shared PCIe TRN transmit interface.
//               Grants one requester at a time, muxes its TRN tx signals onto
//               the endpoint and owns the shared non-posted tag counter.
// Revision    : 1.0 - initial release
// =============================================================================
module trn_tx_arb
    import trn_tx_arb_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int TAGW = TAGW_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_ep,
    input  logic [NREQ-1:0]      drv_ep,
    output logic [NREQ-1:0]      my_trn,
    input  logic [NREQ-1:0]      tag_inc,
    output logic [TAGW-1:0]      tag_trn,
    input  logic [NREQ*64-1:0]   in_trn_td,
    input  logic [NREQ*8-1:0]    in_trn_trem_n,
    input  logic [NREQ-1:0]      in_trn_tsof_n,
    input  logic [NREQ-1:0]      in_trn_teof_n,
    input  logic [NREQ-1:0]      in_trn_tsrc_rdy_n,
    output logic [63:0]          trn_td,
    output logic [7:0]           trn_trem_n,
    output logic                 trn_tsof_n,
    output logic                 trn_teof_n,
    output logic                 trn_tsrc_rdy_n,
    input  logic                 trn_tdst_rdy_n
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_t      r_state;
    arb_state_t      w_next;
    logic [IW-1:0]   r_owner;
    logic [IW-1:0]   r_ptr;
    logic [TAGW-1:0] r_tag;

    logic [IW-1:0]   w_sel;
    logic            w_any;
    logic            w_owns;
    logic            w_active;
    logic            w_own_req;
    logic            w_own_drv;
    logic            w_own_tag;
    logic [63:0]     w_own_td;
    logic [7:0]      w_own_trem;
    logic            w_own_sof;
    logic            w_own_eof;
    logic            w_own_src;

    // Destination-ready goes straight from the endpoint to the requesters
    logic            w_unused;
    assign w_unused = trn_tdst_rdy_n;

    trn_tx_arb_rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .i_req (req_ep),
        .i_ptr (r_ptr),
        .o_sel (w_sel),
        .o_any (w_any)
    );

    assign w_owns   = (r_state == ARB_GRANT) || (r_state == ARB_BUSY);
    assign w_active = w_owns && w_own_drv;
    assign tag_trn  = r_tag;

    // Extract the current owner's handshake and TRN slice
    always_comb begin
        w_own_req  = 1'b0;
        w_own_drv  = 1'b0;
        w_own_tag  = 1'b0;
        w_own_td   = TD_IDLE;
        w_own_trem = TREM_IDLE;
        w_own_sof  = 1'b1;
        w_own_eof  = 1'b1;
        w_own_src  = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            if (r_owner == IW'(i)) begin
                w_own_req  = req_ep[i];
                w_own_drv  = drv_ep[i];
                w_own_tag  = tag_inc[i];
                w_own_td   = in_trn_td[i*64 +: 64];
                w_own_trem = in_trn_trem_n[i*8 +: 8];
                w_own_sof  = in_trn_tsof_n[i];
                w_own_eof  = in_trn_teof_n[i];
                w_own_src  = in_trn_tsrc_rdy_n[i];
            end
        end
    end

    // One-hot grant, held only while the owner is in GRANT or BUSY
    always_comb begin
        my_trn = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_owns && (r_owner == IW'(i))) begin
                my_trn[i] = 1'b1;
            end
        end
    end

    // Endpoint mux: owner's signals only while it actually drives
    always_comb begin
        trn_td         = TD_IDLE;
        trn_trem_n     = TREM_IDLE;
        trn_tsof_n     = 1'b1;
        trn_teof_n     = 1'b1;
        trn_tsrc_rdy_n = 1'b1;
        if (w_active) begin
            trn_td         = w_own_td;
            trn_trem_n     = w_own_trem;
            trn_tsof_n     = w_own_sof;
            trn_teof_n     = w_own_eof;
            trn_tsrc_rdy_n = w_own_src;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ARB_IDLE:    if (w_any) w_next = ARB_GRANT;
            ARB_GRANT: begin
                if (w_own_drv) begin
                    w_next = ARB_BUSY;
                end else if (!w_own_req) begin
                    w_next = ARB_RELEASE;
                end
            end
            ARB_BUSY:    if (!w_own_drv) w_next = ARB_RELEASE;
            ARB_RELEASE: w_next = ARB_IDLE;
            default:     w_next = ARB_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Latch the new owner in IDLE; advance the pointer past it on release
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner <= '0;
            r_ptr   <= '0;
        end else begin
            if ((r_state == ARB_IDLE) && w_any) begin
                r_owner <= w_sel;
            end
            if (r_state == ARB_RELEASE) begin
                r_ptr <= (r_owner == IW'(NREQ-1)) ? '0 : r_owner + IW'(1);
            end
        end
    end

    // Shared tag counter, bumped only by the current owner
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag <= '0;
        end else if (w_owns && w_own_tag) begin
            r_tag <= r_tag + TAGW'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_trn_tx_arb.sv
`default_nettype none
// =============================================================================
// Module      : tb_trn_tx_arb
// Description : Scoreboard bench for trn_tx_arb. Stimulus pushes expected grants
//               and data beats; a negedge monitor pops and compares them.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_trn_tx_arb;

    logic         clk = 1'b0;
    logic         rst;
    logic [2:0]   req_ep, drv_ep, my_trn, tag_inc;
    logic [4:0]   tag_trn;
    logic [191:0] in_trn_td;
    logic [23:0]  in_trn_trem_n;
    logic [2:0]   in_trn_tsof_n, in_trn_teof_n, in_trn_tsrc_rdy_n;
    logic [63:0]  trn_td;
    logic [7:0]   trn_trem_n;
    logic         trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, trn_tdst_rdy_n;

    typedef struct {
        logic [63:0] td;
        logic [7:0]  trem;
        logic        sof;
        logic        eof;
    } beat_t;

    typedef struct {
        logic [2:0] oh;
        int         gap;
    } grant_t;

    beat_t  beat_q[$];
    grant_t grant_q[$];
    beat_t  mb;
    grant_t mg;
    int     n_chk  = 0;
    int     n_fail = 0;

    trn_tx_arb #(.NREQ(3), .TAGW(5)) dut (
        .clk               (clk),
        .rst               (rst),
        .req_ep            (req_ep),
        .drv_ep            (drv_ep),
        .my_trn            (my_trn),
        .tag_inc           (tag_inc),
        .tag_trn           (tag_trn),
        .in_trn_td         (in_trn_td),
        .in_trn_trem_n     (in_trn_trem_n),
        .in_trn_tsof_n     (in_trn_tsof_n),
        .in_trn_teof_n     (in_trn_teof_n),
        .in_trn_tsrc_rdy_n (in_trn_tsrc_rdy_n),
        .trn_td            (trn_td),
        .trn_trem_n        (trn_trem_n),
        .trn_tsof_n        (trn_tsof_n),
        .trn_teof_n        (trn_teof_n),
        .trn_tsrc_rdy_n    (trn_tsrc_rdy_n),
        .trn_tdst_rdy_n    (trn_tdst_rdy_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input int r, input logic [63:0] td, input logic [7:0] trem,
                              input logic sof_n, input logic eof_n);
        drv_ep[r]                = 1'b1;
        in_trn_td[r*64 +: 64]    = td;
        in_trn_trem_n[r*8 +: 8]  = trem;
        in_trn_tsof_n[r]         = sof_n;
        in_trn_teof_n[r]         = eof_n;
        in_trn_tsrc_rdy_n[r]     = 1'b0;
        beat_q.push_back('{td: td, trem: trem, sof: sof_n, eof: eof_n});
    endtask

    task automatic idle_req(input int r);
        drv_ep[r]                = 1'b0;
        in_trn_td[r*64 +: 64]    = 64'hBAD0 + 64'(r);
        in_trn_trem_n[r*8 +: 8]  = 8'hA0 | 8'(r);
        in_trn_tsof_n[r]         = 1'b1;
        in_trn_teof_n[r]         = 1'b1;
        in_trn_tsrc_rdy_n[r]     = 1'b1;
    endtask

    task automatic wait_grant(input int r);
        int t;
        t = 0;
        while (!my_trn[r] && t < 20) begin
            tick();
            t++;
        end
        if (!my_trn[r]) chk("grant_timeout", 64'(my_trn[r]), 64'd1);
    endtask

    // Wait for the grant, drive n beats (td0 + k*inc), then stop driving.
    // Destination-ready is toggled every beat; the grant must hold throughout.
    task automatic serve(input int r, input int n, input logic [63:0] td0, input int inc);
        wait_grant(r);
        for (int k = 0; k < n; k++) begin
            drive_beat(r, td0 + 64'(k * inc), (k == n-1) ? 8'h0F : 8'h00,
                       (k != 0), (k != n-1));
            trn_tdst_rdy_n = ~trn_tdst_rdy_n;
            if (k > 0) chk("grant_held", 64'(my_trn[r]), 64'd1);
            tick();
        end
        idle_req(r);
    endtask

    // Monitor: grant starts and data beats are compared against the queues
    logic [2:0] prev_trn = 3'b000;
    int         gap_cnt  = 0;
    always @(negedge clk) begin
        if (rst) begin
            prev_trn <= 3'b000;
            gap_cnt  <= 0;
        end else begin
            if ((my_trn != 3'b000) && (prev_trn == 3'b000)) begin
                if (grant_q.size() == 0) begin
                    chk("unexpected_grant", 64'(my_trn), 64'd0);
                end else begin
                    mg = grant_q.pop_front();
                    chk("grant_owner", 64'(my_trn), 64'(mg.oh));
                    if (mg.gap != 0) chk("grant_gap", 64'(gap_cnt), 64'(mg.gap));
                end
            end
            gap_cnt  <= (my_trn == 3'b000) ? gap_cnt + 1 : 0;
            prev_trn <= my_trn;
            if (trn_tsrc_rdy_n == 1'b0) begin
                chk("src_rdy_with_grant", 64'(my_trn != 3'b000), 64'd1);
                if (beat_q.size() == 0) begin
                    chk("unexpected_beat", 64'(trn_tsrc_rdy_n), 64'd1);
                end else begin
                    mb = beat_q.pop_front();
                    chk("beat_td", trn_td, mb.td);
                    chk("beat_ctl", 64'({trn_trem_n, trn_tsof_n, trn_teof_n}),
                        64'({mb.trem, mb.sof, mb.eof}));
                end
            end else begin
                chk("idle_td", trn_td, 64'd0);
                chk("idle_ctl", 64'({trn_trem_n, trn_tsof_n, trn_teof_n}), 64'h3FF);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset with requesters driving noise: outputs must stay idle
        rst               = 1'b1;
        req_ep            = 3'b000;
        drv_ep            = 3'b111;
        tag_inc           = 3'b111;
        trn_tdst_rdy_n    = 1'b0;
        in_trn_td         = {64'hBAD2, 64'hBAD1, 64'hBAD0};
        in_trn_trem_n     = {8'hA2, 8'hA1, 8'hA0};
        in_trn_tsof_n     = 3'b000;
        in_trn_teof_n     = 3'b000;
        in_trn_tsrc_rdy_n = 3'b000;
        tick();
        tick();
        chk("reset_my_trn", 64'(my_trn), 64'd0);
        chk("reset_tag", 64'(tag_trn), 64'd0);
        chk("reset_src_rdy", 64'(trn_tsrc_rdy_n), 64'd1);
        chk("reset_td", trn_td, 64'd0);
        chk("reset_ctl", 64'({trn_trem_n, trn_tsof_n, trn_teof_n}), 64'h3FF);
        for (int i = 0; i < 3; i++) idle_req(i);
        tag_inc = 3'b000;
        rst     = 1'b0;
        tick();

        // Round robin with all three requesting: 0,1,2,0, two-cycle gaps
        grant_q.push_back('{oh: 3'b001, gap: 0});
        grant_q.push_back('{oh: 3'b010, gap: 2});
        grant_q.push_back('{oh: 3'b100, gap: 2});
        grant_q.push_back('{oh: 3'b001, gap: 2});
        req_ep = 3'b111;
        serve(0, 2, 64'h1000, 1);
        serve(1, 2, 64'h2000, 1);
        serve(2, 2, 64'h3000, 1);
        serve(0, 2, 64'h4000, 1);
        req_ep = 3'b000;
        repeat (3) tick();

        // Single requester: one-cycle grant latency, four beats of A5
        grant_q.push_back('{oh: 3'b001, gap: 0});
        req_ep = 3'b001;
        tick();
        chk("grant_latency", 64'(my_trn), 64'd1);
        serve(0, 4, 64'hA5, 0);
        chk("last_busy_grant", 64'(my_trn), 64'd1);
        req_ep = 3'b000;
        tick();
        chk("release_grant", 64'(my_trn), 64'd0);
        repeat (2) tick();

        // Requester 1 withdraws without driving; pointer moves to 2
        grant_q.push_back('{oh: 3'b010, gap: 0});
        req_ep = 3'b010;
        wait_grant(1);
        req_ep = 3'b000;
        tick();
        chk("withdraw_release", 64'(my_trn), 64'd0);
        grant_q.push_back('{oh: 3'b100, gap: 2});
        req_ep = 3'b111;
        serve(2, 1, 64'h5000, 0);
        req_ep = 3'b000;
        repeat (3) tick();

        // Tag counter: preset to 30, ignore non-owners, wrap 31 -> 0
        grant_q.push_back('{oh: 3'b001, gap: 0});
        req_ep = 3'b001;
        wait_grant(0);
        for (int i = 0; i < 30; i++) begin
            tag_inc = 3'b001;
            tick();
        end
        tag_inc = 3'b000;
        chk("tag_preset", 64'(tag_trn), 64'd30);
        tag_inc           = 3'b110;
        drv_ep            = 3'b110;
        in_trn_tsrc_rdy_n = 3'b001;
        tick();
        chk("nonowner_src_rdy", 64'(trn_tsrc_rdy_n), 64'd1);
        tick();
        chk("nonowner_tag", 64'(tag_trn), 64'd30);
        tag_inc = 3'b000;
        for (int i = 0; i < 3; i++) idle_req(i);
        tag_inc = 3'b001;
        tick();
        tag_inc = 3'b000;
        chk("tag_31", 64'(tag_trn), 64'd31);
        tag_inc = 3'b001;
        tick();
        tag_inc = 3'b000;
        chk("tag_wrap", 64'(tag_trn), 64'd0);
        req_ep = 3'b000;
        tick();
        tag_inc = 3'b001;
        repeat (2) tick();
        tag_inc = 3'b000;
        chk("tag_outside_grant", 64'(tag_trn), 64'd0);
        tick();

        // Destination-ready toggling during BUSY does not disturb the grant
        grant_q.push_back('{oh: 3'b010, gap: 0});
        req_ep = 3'b010;
        serve(1, 4, 64'hC000, 16);
        req_ep = 3'b000;
        repeat (3) tick();

        // Reset in the middle of a BUSY transfer by requester 2
        grant_q.push_back('{oh: 3'b100, gap: 0});
        req_ep = 3'b100;
        wait_grant(2);
        tag_inc = 3'b100;
        drive_beat(2, 64'hD000, 8'h00, 1'b0, 1'b1);
        tick();
        tag_inc = 3'b000;
        drive_beat(2, 64'hD001, 8'h00, 1'b1, 1'b1);
        chk("tag_before_reset", 64'(tag_trn), 64'd1);
        tick();
        rst = 1'b1;
        tick();
        chk("reset_mid_my_trn", 64'(my_trn), 64'd0);
        chk("reset_mid_src_rdy", 64'(trn_tsrc_rdy_n), 64'd1);
        chk("reset_mid_tag", 64'(tag_trn), 64'd0);
        rst = 1'b0;
        idle_req(2);
        grant_q.push_back('{oh: 3'b010, gap: 0});
        req_ep = 3'b110;
        serve(1, 1, 64'hE000, 0);
        req_ep = 3'b000;
        repeat (4) tick();

        chk("grant_q_empty", 64'(grant_q.size()), 64'd0);
        chk("beat_q_empty", 64'(beat_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
